fft_job_arbiter: RTL and testbench

FFT_JOB_ARBITER -- requirements
Module: fft_job_arbiter

---
 rtl/fft_pkg.sv | 17 +
 rtl/rr_arb2.sv | 15 +
 rtl/fft_job_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_fft_job_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared defaults and FSM state type for the FFT job arbiter.
package fft_pkg;

    localparam int unsigned DW_DEF     = 64;
    localparam int unsigned N_LOG2_DEF = 8;
    localparam int unsigned TMO_DEF    = 4096;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_ABORT = 3'd5
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the requester not served last wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/fft_job_arbiter.sv
// Time-shares one streaming FFT core between two frame requesters, with
// underrun and watchdog aborts and a registered result stream.
module fft_job_arbiter
    import fft_pkg::*;
#(
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned N_LOG2 = N_LOG2_DEF,
    parameter int unsigned TMO    = TMO_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req,
    output logic [1:0]      gnt,
    input  logic [1:0]      in_valid,
    input  logic [2*DW-1:0] in_data,
    output logic [1:0]      in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic            out_id,
    output logic            out_last,
    output logic            err,
    output logic            fft_start,
    output logic [DW-1:0]   fft_x,
    input  logic [DW-1:0]   fft_dout,
    input  logic            fft_dout_valid,
    input  logic            fft_done,
    output logic            fft_abort
);

    localparam int unsigned   CW     = N_LOG2 + 1;
    localparam int unsigned   WW     = $clog2(TMO + 1);
    localparam logic [CW-1:0] N_PTS  = {1'b1, {N_LOG2{1'b0}}};
    localparam logic [CW-1:0] N_LAST = N_PTS - CW'(1);
    localparam logic [WW-1:0] TMO_M1 = WW'(TMO - 1);

    state_e          state_q, state_d;
    logic [1:0]      gnt_q, gnt_d;
    logic            gidx_q, gidx_d;
    logic            last_q, last_d;
    logic [CW-1:0]   in_cnt_q, in_cnt_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic [1:0]      in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_id_q, out_id_d;
    logic            out_last_q, out_last_d;
    logic            err_q, err_d;
    logic            start_q, start_d;
    logic [DW-1:0]   fft_x_q, fft_x_d;
    logic            abort_q, abort_d;

    logic [1:0]      arb_gnt;
    logic            sel_valid;
    logic [DW-1:0]   sel_data;
    logic            abort_job;
    logic            end_job;

    rr_arb2 u_arb (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (arb_gnt)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gidx_d      = gidx_q;
        last_d      = last_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        wd_d        = wd_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        fft_x_d     = fft_x_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        err_d       = 1'b0;
        abort_d     = 1'b0;
        abort_job   = 1'b0;
        end_job     = 1'b0;
        sel_valid   = in_valid[gidx_q];
        sel_data    = gidx_q ? in_data[2*DW-1:DW] : in_data[DW-1:0];

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    gnt_d   = arb_gnt;
                    gidx_d  = arb_gnt[1];
                    state_d = S_START;
                end
            end
            S_START: state_d = S_LOAD;
            S_LOAD: begin
                // The core cannot stall, so a missing sample kills the job.
                if (!sel_valid) begin
                    abort_job = 1'b1;
                end else begin
                    fft_x_d  = sel_data;
                    in_cnt_d = in_cnt_q + CW'(1);
                    if (in_cnt_q == N_LAST) begin
                        state_d = S_RUN;
                        wd_d    = '0;
                    end
                end
            end
            S_RUN, S_DRAIN: begin
                out_id_d = gidx_q;
                wd_d     = wd_q + WW'(1);
                if (fft_dout_valid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = fft_dout;
                    out_last_d  = (out_cnt_q == N_LAST);
                    out_cnt_d   = out_cnt_q + CW'(1);
                    if (state_q == S_RUN) state_d = S_DRAIN;
                end
                if (fft_done) begin
                    state_d = S_IDLE;
                    err_d   = (out_cnt_d != N_PTS);
                    end_job = 1'b1;
                end else if (wd_q == TMO_M1) begin
                    abort_job = 1'b1;
                end
            end
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort_job) begin
            state_d = S_ABORT;
            err_d   = 1'b1;
            abort_d = 1'b1;
        end
        if (abort_job || end_job) begin
            gnt_d     = '0;
            last_d    = gidx_q;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            wd_d      = '0;
        end

        in_ready_d = (state_d == S_LOAD) ? gnt_d : '0;
        start_d    = (state_d == S_START);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            gidx_q      <= 1'b0;
            last_q      <= 1'b1;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            wd_q        <= '0;
            in_ready_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            fft_x_q     <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gidx_q      <= gidx_d;
            last_q      <= last_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            wd_q        <= wd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            start_q     <= start_d;
            fft_x_q     <= fft_x_d;
            abort_q     <= abort_d;
        end
    end

    assign gnt       = gnt_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_last  = out_last_q;
    assign err       = err_q;
    assign fft_start = start_q;
    assign fft_x     = fft_x_q;
    assign fft_abort = abort_q;

endmodule

// File: tb/tb_fft_job_arbiter.sv
// Randomized bench: drives two requesters and a behavioural FFT core model,
// checking grants, load stream, result stream and abort behaviour.
module tb_fft_job_arbiter;

    localparam int unsigned DW     = 64;
    localparam int unsigned N_LOG2 = 8;
    localparam int unsigned TMO    = 4096;
    localparam int          N      = 1 << N_LOG2;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req;
    logic [1:0]      gnt;
    logic [1:0]      in_valid;
    logic [2*DW-1:0] in_data;
    logic [1:0]      in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_id;
    logic            out_last;
    logic            err;
    logic            fft_start;
    logic [DW-1:0]   fft_x;
    logic [DW-1:0]   fft_dout;
    logic            fft_dout_valid;
    logic            fft_done;
    logic            fft_abort;

    int tests;
    int fails;
    int cyc = 0;
    int last_srv;
    bit            pend_v;
    logic [DW-1:0] pend_d;
    bit            pend_last;
    int            out_idx;
    logic          exp_id;

    fft_job_arbiter #(.DW(DW), .N_LOG2(N_LOG2), .TMO(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .gnt            (gnt),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_id         (out_id),
        .out_last       (out_last),
        .err            (err),
        .fft_start      (fft_start),
        .fft_x          (fft_x),
        .fft_dout       (fft_dout),
        .fft_dout_valid (fft_dout_valid),
        .fft_done       (fft_done),
        .fft_abort      (fft_abort)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of the core model: check the result stream expected from the
    // previous cycle, then present this cycle's core outputs.
    task automatic core_cycle(input bit v, input logic [DW-1:0] d, input bit dn, input bit live);
        check("out_valid", out_valid, pend_v);
        check("out_last", out_last, pend_last);
        if (pend_v) begin
            check("out_data", out_data, pend_d);
            check("out_id", out_id, exp_id);
        end
        fft_dout_valid = v;
        fft_dout       = d;
        fft_done       = dn;
        pend_v    = v && live;
        pend_d    = d;
        pend_last = v && live && (out_idx == N - 1);
        if (pend_v) out_idx++;
        step();
    endtask

    // mode: 0 normal, 1 core never finishes, 2 core finishes short, 3 reset mid-run
    task automatic run_job(input logic [1:0] rq, input int mode, input int drop_at, input bit hold);
        int g, waitc, n_emit, n_target, n, t_loaded;
        logic [DW-1:0] sent[$];
        logic [DW-1:0] core_x[$];
        bit v;
        g = (rq == 2'b11) ? (1 - last_srv) : ((rq == 2'b10) ? 1 : 0);
        out_idx = 0;
        exp_id  = g[0];
        pend_v  = 1'b0;
        req     = rq;
        step();
        waitc = 0;
        while (gnt == 2'b00 && waitc < 8) begin
            step();
            waitc++;
        end
        check("grant", gnt, 64'(1) << g);
        check("start", fft_start, 1);
        if (!hold) req = 2'b00;
        step();
        check("start_pulse", fft_start, 0);

        for (int k = 0; k < N; k++) begin
            check("in_ready", in_ready, 64'(1) << g);
            if (k > 0) begin
                check("fft_x", fft_x, sent[k-1]);
                core_x.push_back(fft_x);
            end
            in_data = {$urandom, $urandom, $urandom, $urandom};
            sent.push_back(g ? in_data[2*DW-1:DW] : in_data[DW-1:0]);
            in_valid[g]     = (k != drop_at);
            in_valid[1 - g] = 1'($urandom);
            v = ($urandom_range(0, 7) == 0);
            core_cycle(v, {$urandom, $urandom}, 1'b0, 1'b0);
            if (k == drop_at) begin
                in_valid = '0;
                check("abort_err", err, 1);
                check("abort_pulse", fft_abort, 1);
                check("abort_gnt", gnt, 0);
                check("abort_ready", in_ready, 0);
                core_cycle(1'b0, '0, 1'b0, 1'b0);
                check("abort_clear", {err, fft_abort}, 0);
                last_srv = g;
                return;
            end
        end
        in_valid = '0;
        check("ready_drop", in_ready, 0);
        check("fft_x_last", fft_x, sent[N-1]);
        core_x.push_back(fft_x);
        t_loaded = cyc;

        repeat ($urandom_range(1, 4)) core_cycle(1'b0, '0, 1'b0, 1'b1);
        n_target = (mode == 2) ? N / 2 : N;
        n_emit = 0;
        n = 0;
        while (n_emit < n_target && n < 4 * N) begin
            v = ($urandom_range(0, 3) != 0);
            core_cycle(v, v ? core_x[n_emit] + 64'd1000 : 64'($urandom), 1'b0, 1'b1);
            if (v) n_emit++;
            n++;
            if (mode == 3 && n_emit == 10) begin
                fft_dout_valid = 1'b0;
                #2 rst = 1'b0;
                #1;
                check("rst_ctl", {gnt, in_ready, out_valid, out_id, out_last, err, fft_start, fft_abort}, 0);
                check("rst_out_data", out_data, 0);
                check("rst_fft_x", fft_x, 0);
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                last_srv = 1;
                pend_v   = 1'b0;
                return;
            end
        end

        if (mode != 1) begin
            core_cycle(1'b0, '0, 1'b1, 1'b1);
            fft_done = 1'b0;
            check("done_gnt", gnt, 0);
            check("done_err", err, (mode == 2));
            check("done_abort", fft_abort, 0);
            last_srv = g;
            if (mode == 2) begin
                core_cycle(1'b0, '0, 1'b0, 1'b0);
                check("short_err_clear", err, 0);
            end
        end else begin
            n = 0;
            while (err !== 1'b1 && n < TMO + 64) begin
                core_cycle(1'b0, '0, 1'b0, 1'b1);
                n++;
            end
            check("tmo_latency", 64'(cyc - t_loaded), TMO);
            check("tmo_abort", fft_abort, 1);
            check("tmo_gnt", gnt, 0);
            last_srv = g;
            core_cycle(1'b0, '0, 1'b0, 1'b0);
            check("tmo_err_clear", err, 0);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        req = '0;
        in_valid = '0;
        in_data = '0;
        fft_dout = '0;
        fft_dout_valid = 1'b0;
        fft_done = 1'b0;
        last_srv = 1;
        pend_v = 1'b0;
        pend_d = '0;
        pend_last = 1'b0;
        out_idx = 0;
        exp_id = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {gnt, in_ready, out_valid, out_id, out_last, err, fft_start, fft_abort}, 0);
        check("reset_out_data", out_data, 0);
        check("reset_fft_x", fft_x, 0);
        rst = 1'b1;
        step();

        core_cycle(1'b1, 64'hDEAD_BEEF, 1'b0, 1'b0);
        core_cycle(1'b0, '0, 1'b0, 1'b0);

        run_job(2'b11, 0, -1, 1'b1);
        run_job(2'b11, 0, -1, 1'b1);
        run_job(2'b11, 0, -1, 1'b0);
        run_job(2'b01, 0, -1, 1'b0);
        run_job(2'b10, 0, 100, 1'b0);
        run_job(2'b11, 0, -1, 1'b0);
        run_job(2'b01, 2, -1, 1'b0);
        run_job(2'b10, 1, -1, 1'b0);
        run_job(2'b01, 3, -1, 1'b0);
        run_job(2'b10, 0, -1, 1'b0);
        repeat (3) run_job(2'($urandom_range(1, 3)), 0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL time_limit: simulation did not complete, tests %0d", tests);
        $fatal(1, "time limit");
    end

endmodule
